// File: rtl/alu_logic_pkg.sv
// ----------------------------------------------------------------------------
// alu_logic_pkg
// Shared definitions for the bitwise logic unit:
//   - alu_op_e : 3-bit operation select encoding
//   - CNT_W    : width of the completed-transfer counter
// ----------------------------------------------------------------------------
package alu_logic_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_ANDN   = 3'd6,   // a & ~b
        OP_PASS_A = 3'd7
    } alu_op_e;

endpackage : alu_logic_pkg

// File: rtl/alu_logic_fifo.sv
// ----------------------------------------------------------------------------
// alu_logic_fifo
// Result buffer: DEPTH-entry FIFO (DEPTH a power of two) with pointers that
// wrap modulo DEPTH and a synchronous flush.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : discard all entries at the next edge (overrides push/pop)
//   push, wdata : write one entry (caller guarantees !full)
//   pop         : remove the head entry (caller guarantees !empty)
//   rdata       : head entry
//   full, empty : occupancy == DEPTH / occupancy == 0
// ----------------------------------------------------------------------------
module alu_logic_fifo #(
    parameter int unsigned DW    = 35,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Storage is not reset: entries are only visible while r_count says so.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Power-of-two DEPTH: natural overflow of AW bits is the modulo wrap.
            if (push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule : alu_logic_fifo

// File: rtl/alu_logic_unit.sv
// ----------------------------------------------------------------------------
// alu_logic_unit
// Bitwise logic unit with valid/ready handshakes on both sides. Each accepted
// beat computes op(a, b) plus zero/ones/parity flags and stores them in a
// DEPTH-entry result FIFO; the head entry is presented on the output side.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : synchronous discard of all buffered results
//   in_valid / in_ready   : input handshake (op, a, b sampled on accept)
//   op [2:0]              : operation select (see alu_op_e)
//   a, b [WIDTH-1:0]      : operands
//   out_valid / out_ready : output handshake
//   result [WIDTH-1:0]    : head result (0 when !out_valid)
//   zero, ones, parity    : head result flags (0 when !out_valid)
//   xfer_count [15:0]     : completed output transfers, wraps at 0xFFFF
// ----------------------------------------------------------------------------
module alu_logic_unit
    import alu_logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ones,
    output logic             parity,
    output logic [CNT_W-1:0] xfer_count
);

    // Entry layout: {parity, ones, zero, result}
    localparam int unsigned DW = WIDTH + 3;

    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_ones;
    logic             w_parity;
    logic [DW-1:0]    w_wdata;
    logic [DW-1:0]    w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] r_xfer_count;

    always_comb begin
        w_res = '0;
        unique case (alu_op_e'(op))
            OP_AND:    w_res = a & b;
            OP_OR:     w_res = a | b;
            OP_XOR:    w_res = a ^ b;
            OP_NAND:   w_res = ~(a & b);
            OP_NOR:    w_res = ~(a | b);
            OP_XNOR:   w_res = ~(a ^ b);
            OP_ANDN:   w_res = a & ~b;
            OP_PASS_A: w_res = a;
        endcase
    end

    assign w_zero   = (w_res == '0);
    assign w_ones   = &w_res;
    assign w_parity = ^w_res;
    assign w_wdata  = {w_parity, w_ones, w_zero, w_res};

    // rst_n gates in_ready so it reads 0 throughout reset, not just after it.
    // Full is judged on start-of-cycle occupancy; a concurrent pop does not help.
    assign in_ready  = rst_n && !w_full && !flush;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    alu_logic_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    // A pop coinciding with flush is discarded along with the data, so it
    // does not count as a completed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_pop && !flush) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
        end
    end

    assign result     = out_valid ? w_rdata[WIDTH-1:0] : '0;
    assign zero       = out_valid && w_rdata[WIDTH];
    assign ones       = out_valid && w_rdata[WIDTH+1];
    assign parity     = out_valid && w_rdata[WIDTH+2];
    assign xfer_count = r_xfer_count;

endmodule : alu_logic_unit

// File: doc/alu_logic_unit.md
ALU_LOGIC_UNIT -- requirements
Module: alu_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and result width in bits (legal values 1..64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning result-buffer entries (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous discard of all buffered results.
REQ-006 SHALL have port in_valid, input, 1 bit: an operand beat is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port op, input, 3 bits: operation select, sampled with the operands.
REQ-009 SHALL have port a, input, WIDTH bits: operand A.
REQ-010 SHALL have port b, input, WIDTH bits: operand B.
REQ-011 SHALL have port out_valid, output, 1 bit: head result is present.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer takes the head result.
REQ-013 SHALL have port result, output, WIDTH bits: head result value.
REQ-014 SHALL have port zero, output, 1 bit: head result == 0.
REQ-015 SHALL have port ones, output, 1 bit: head result is all ones.
REQ-016 SHALL have port parity, output, 1 bit: XOR-reduction of the head result.
REQ-017 SHALL have port xfer_count, output, 16 bits: number of completed output transfers.

Function
REQ-018 Op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~b), 7 PASS_A; all eight codes are legal and bitwise per lane.
REQ-019 An input beat SHALL be accepted when in_valid && in_ready at the clock edge; an output beat SHALL complete when out_valid && out_ready at the clock edge.
REQ-020 in_ready SHALL equal !full && !flush, where full means occupancy == DEPTH at cycle start; a pop in the same cycle does not raise in_ready.
REQ-021 The result and the zero, ones and parity flags SHALL be computed combinationally at accept time and stored in the buffer; latency is one cycle (out_valid high in the cycle after acceptance into an empty buffer).
REQ-022 out_valid SHALL equal occupancy != 0; result, zero, ones and parity SHALL reflect the head entry and hold stable while out_valid && !out_ready.
REQ-023 The buffer SHALL be FIFO-ordered; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 A simultaneous push and pop SHALL leave occupancy unchanged, including at occupancy 1.
REQ-025 A pop while the buffer is empty SHALL be impossible: out_valid is 0, so out_ready is ignored.
REQ-026 flush SHALL set occupancy and both pointers to 0 at the next edge; a pop in the flush cycle is not counted.
REQ-027 xfer_count SHALL increment by 1 per completed output transfer and wrap from 0xFFFF to 0x0000.
REQ-028 When out_valid is 0, result and the flags SHALL drive 0.

Reset
REQ-029 While rst_n is low, asynchronously: occupancy, pointers and xfer_count SHALL be 0; in_ready, out_valid, result, zero, ones and parity SHALL be 0.
REQ-030 in_ready SHALL rise in the first cycle after rst_n deasserts; buffered data SHALL be discarded when reset asserts mid-operation.

Structure
REQ-031 Package alu_logic_pkg SHALL hold the op encoding constants and the 16-bit count width.
REQ-032 Sub-module alu_logic_fifo, parametrised by data width and DEPTH, SHALL implement the buffer; alu_logic_unit holds the op decode and flag logic.

Verification
REQ-033 op=AND, a=0xF0F0F0F0, b=0xFF00FF00, out_ready=1 -> next cycle result=0xF000F000, zero=0, ones=0, parity=0.
REQ-034 op=NOR, a=b=0x00000000 -> result=0xFFFFFFFF, ones=1; then op=XOR, a=b=0x12345678 -> result=0, zero=1.
REQ-035 out_ready=0, push 3 beats -> after 2 accepts in_ready=0; raise out_ready -> beats emerge in order; 3rd beat accepted only after a pop frees an entry.
REQ-036 Continuous in_valid and out_ready for 20 beats -> one result per cycle, xfer_count=20.
REQ-037 Fill buffer, assert flush with in_valid high -> in_ready=0, out_valid=0 next cycle, xfer_count unchanged.
REQ-038 Preload xfer_count to 0xFFFF via transfers, complete one more -> 0x0000; assert rst_n=0 mid-stream -> all outputs 0 immediately.
